sha_stream_arbiter: RTL

- Packet-granular round-robin arbiter that shares one SHA-1 block-alignment/padding datapath between NUM_CH independent 512-bit AXI-Stream message sources.
- Grants one source at a time, holds the grant until that source's tlast beat is accepted, and forwards beats through a registered output stage.
- Tags each forwarded beat with the source index so downstream digest results can be routed back.

---
 rtl/sha_arb_pkg.sv | 28 ++
 rtl/sha_stream_arbiter_if.sv | 31 +++
 rtl/sha_axis_reg_slice.sv | 56 +++++
 rtl/sha_stream_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/sha_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick function for sha_stream_arbiter.
package sha_arb_pkg;

    localparam int unsigned SHA_DATA_W = 512;
    localparam int unsigned SHA_KEEP_W = 64;
    localparam int unsigned MAX_CH     = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

    // Callers zero-extend req to MAX_CH; unused upper bits are zero, so a mod-16 scan
    // visits the live channels in the same order as a mod-NUM_CH scan.
    function automatic logic [3:0] rr_next(input logic [MAX_CH-1:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sha_stream_arbiter_if.sv
// Bundle of NUM_CH input AXI-Stream sources and the single tagged output stream.
interface sha_stream_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ID_W   = $clog2(NUM_CH)
) ();

    logic [NUM_CH-1:0]                         o_tready_in;
    logic [NUM_CH-1:0]                         i_tvalid_in;
    logic [NUM_CH*sha_arb_pkg::SHA_DATA_W-1:0] i_tdata_in;
    logic [NUM_CH*sha_arb_pkg::SHA_KEEP_W-1:0] i_tkeep_in;
    logic [NUM_CH-1:0]                         i_tlast_in;
    logic                                      i_tready_out;
    logic                                      o_tvalid_out;
    logic [sha_arb_pkg::SHA_DATA_W-1:0]        o_tdata_out;
    logic [sha_arb_pkg::SHA_KEEP_W-1:0]        o_tkeep_out;
    logic                                      o_tlast_out;
    logic [ID_W-1:0]                           o_tid_out;

    // Environment side: sources and downstream sink.
    modport master (
        input  o_tready_in, o_tvalid_out, o_tdata_out, o_tkeep_out, o_tlast_out, o_tid_out,
        output i_tvalid_in, i_tdata_in, i_tkeep_in, i_tlast_in, i_tready_out
    );

    // Arbiter side.
    modport slave (
        input  i_tvalid_in, i_tdata_in, i_tkeep_in, i_tlast_in, i_tready_out,
        output o_tready_in, o_tvalid_out, o_tdata_out, o_tkeep_out, o_tlast_out, o_tid_out
    );

endinterface

// File: rtl/sha_axis_reg_slice.sv
// Single-entry AXI-Stream output register carrying data, keep, last and source tag.
module sha_axis_reg_slice
    import sha_arb_pkg::*;
#(
    parameter int unsigned ID_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [SHA_DATA_W-1:0] i_data,
    input  logic [SHA_KEEP_W-1:0] i_keep,
    input  logic                  i_last,
    input  logic [ID_W-1:0]       i_tid,
    input  logic                  i_tready,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [SHA_DATA_W-1:0] o_data,
    output logic [SHA_KEEP_W-1:0] o_keep,
    output logic                  o_last,
    output logic [ID_W-1:0]       o_tid
);

    logic                  r_valid;
    logic [SHA_DATA_W-1:0] r_data;
    logic [SHA_KEEP_W-1:0] r_keep;
    logic                  r_last;
    logic [ID_W-1:0]       r_tid;

    // Empty, or draining this cycle, means a new beat can be taken.
    assign o_ready = !r_valid || i_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_tid   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
            r_tid   <= i_tid;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;
    assign o_tid   = r_tid;

endmodule

// File: rtl/sha_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one SHA-1 alignment datapath.
// Optional macro SHA_ARB_PKT_CNT_EN adds per-channel accepted-packet counters on o_pkt_cnt.
module sha_stream_arbiter
    import sha_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ID_W   = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    sha_stream_arbiter_if.slave    bus
`ifdef SHA_ARB_PKT_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]   o_pkt_cnt
`endif
);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_rr_ptr;

    logic [ID_W-1:0]       w_pick;
    logic [NUM_CH-1:0]     w_tready;
    logic                  w_slice_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_valid;
    logic [SHA_DATA_W-1:0] w_data;
    logic [SHA_KEEP_W-1:0] w_keep;
    logic                  w_out_last;
    logic [ID_W-1:0]       w_tid;

    assign w_pick = ID_W'(rr_next(MAX_CH'(bus.i_tvalid_in), 4'(r_rr_ptr)));

    always_comb begin
        w_tready = '0;
        if (r_state == ARB_LOCK) begin
            w_tready[r_grant] = w_slice_ready;
        end
    end

    assign w_accept = (r_state == ARB_LOCK) && bus.i_tvalid_in[r_grant] && w_slice_ready;
    assign w_last   = bus.i_tlast_in[r_grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|bus.i_tvalid_in) begin
                        r_grant <= w_pick;
                        r_state <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (w_accept && w_last) begin
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= (r_grant == ID_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    sha_axis_reg_slice #(
        .ID_W (ID_W)
    ) u_slice (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_data   (bus.i_tdata_in[r_grant*SHA_DATA_W +: SHA_DATA_W]),
        .i_keep   (bus.i_tkeep_in[r_grant*SHA_KEEP_W +: SHA_KEEP_W]),
        .i_last   (w_last),
        .i_tid    (r_grant),
        .i_tready (bus.i_tready_out),
        .o_ready  (w_slice_ready),
        .o_valid  (w_valid),
        .o_data   (w_data),
        .o_keep   (w_keep),
        .o_last   (w_out_last),
        .o_tid    (w_tid)
    );

    assign bus.o_tready_in  = w_tready;
    assign bus.o_tvalid_out = w_valid;
    assign bus.o_tdata_out  = w_data;
    assign bus.o_tkeep_out  = w_keep;
    assign bus.o_tlast_out  = w_out_last;
    assign bus.o_tid_out    = w_tid;

`ifdef SHA_ARB_PKT_CNT_EN
    logic [NUM_CH*32-1:0] r_pkt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt <= '0;
        end else if (w_accept && w_last) begin
            r_pkt_cnt[r_grant*32 +: 32] <= r_pkt_cnt[r_grant*32 +: 32] + 32'd1;
        end
    end

    assign o_pkt_cnt = r_pkt_cnt;
`endif

endmodule
